// File: rtl/noc_pkg.sv
// Shared router definitions: port codes, port count/width and the
// per-output arbitration state.
package noc_pkg;

  localparam int unsigned NPORTS = 5;
  localparam int unsigned PSIZE  = 3;

  typedef enum logic [PSIZE-1:0] {
    PORT_N       = 3'b000,
    PORT_S       = 3'b001,
    PORT_E       = 3'b010,
    PORT_W       = 3'b011,
    PORT_L       = 3'b100,
    PORT_INVALID = 3'b111
  } port_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Cyclic successor over the valid port indices 0..NPORTS-1.
  function automatic logic [PSIZE-1:0] next_port(input logic [PSIZE-1:0] p);
    return (p == PSIZE'(NPORTS - 1)) ? '0 : p + PSIZE'(1);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant and crossbar-control bundle between input modules and the allocator.
interface switch_allocator_if;
  import noc_pkg::*;

  logic [NPORTS-1:0]       req_valid;
  logic [NPORTS*PSIZE-1:0] req_port;
  logic [NPORTS-1:0]       req_last;
  logic [NPORTS-1:0]       out_ready;
  logic [NPORTS-1:0]       grant;
  logic [NPORTS-1:0]       out_valid;
  logic [NPORTS*PSIZE-1:0] out_sel;
  logic [NPORTS-1:0]       out_lock;
  logic                    err_invalid;

  modport master (
    output req_valid, req_port, req_last, out_ready,
    input  grant, out_valid, out_sel, out_lock, err_invalid
  );

  modport slave (
    input  req_valid, req_port, req_last, out_ready,
    output grant, out_valid, out_sel, out_lock, err_invalid
  );

endinterface

// File: rtl/switch_allocator_output_arbiter.sv
// One output port: round-robin pick among candidates, wormhole lock to the
// owner until its tail flit.
module output_arbiter
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] cand,
  input  logic              ready,
  input  logic [NPORTS-1:0] last,
  output logic [NPORTS-1:0] grant,
  output logic              lock,
  output logic [PSIZE-1:0]  owner
);

  arb_state_e       state_q, state_d;
  logic [PSIZE-1:0] owner_q, owner_d;
  logic [PSIZE-1:0] rr_ptr_q, rr_ptr_d;
  logic [PSIZE-1:0] win, idx;
  logic             found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant    = '0;
    found    = 1'b0;
    win      = rr_ptr_q;
    idx      = rr_ptr_q;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = next_port(idx);
    end

    if (ready) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (found) begin
            grant[win] = 1'b1;
            if (last[win]) begin
              rr_ptr_d = next_port(win);
            end else begin
              state_d = ARB_LOCKED;
              owner_d = win;
            end
          end
        end
        ARB_LOCKED: begin
          if (cand[owner_q]) begin
            grant[owner_q] = 1'b1;
            if (last[owner_q]) begin
              state_d  = ARB_IDLE;
              rr_ptr_d = next_port(owner_q);
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign lock  = (state_q == ARB_LOCKED);
  assign owner = owner_q;

endmodule

// File: rtl/switch_allocator.sv
// 5-port switch allocator: decodes route requests, arbitrates each output and
// registers the crossbar select/valid one cycle after the grant.
module switch_allocator
  import noc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  switch_allocator_if.slave   bus
);

  logic [NPORTS-1:0]       cand_raw   [NPORTS];
  logic [NPORTS-1:0]       busy_other [NPORTS];
  logic [NPORTS-1:0]       arb_grant  [NPORTS];
  logic [PSIZE-1:0]        owner      [NPORTS];
  logic [NPORTS-1:0]       lock;
  logic [NPORTS-1:0]       grant_any;
  logic [NPORTS-1:0]       valid_d;
  logic [NPORTS*PSIZE-1:0] sel_d;
  logic                    invalid_d;

  // An input that owns a locked output is hidden from every other output.
  always_comb begin
    invalid_d = 1'b0;
    for (int unsigned o = 0; o < NPORTS; o++) begin
      cand_raw[o]   = '0;
      busy_other[o] = '0;
    end
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (bus.req_valid[i] && (bus.req_port[i*PSIZE +: PSIZE] >= PSIZE'(NPORTS)))
        invalid_d = 1'b1;
      for (int unsigned o = 0; o < NPORTS; o++) begin
        if (bus.req_valid[i] && (bus.req_port[i*PSIZE +: PSIZE] == PSIZE'(o)))
          cand_raw[o][i] = 1'b1;
      end
    end
    for (int unsigned o = 0; o < NPORTS; o++) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if ((p != o) && lock[p])
          busy_other[o][owner[p]] = 1'b1;
      end
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    output_arbiter u_arb (
      .clk   (clk),
      .reset (reset),
      .cand  (cand_raw[o] & ~busy_other[o]),
      .ready (bus.out_ready[o]),
      .last  (bus.req_last),
      .grant (arb_grant[o]),
      .lock  (lock[o]),
      .owner (owner[o])
    );
  end

  always_comb begin
    grant_any = '0;
    valid_d   = '0;
    sel_d     = '0;
    for (int unsigned o = 0; o < NPORTS; o++) begin
      grant_any  = grant_any | arb_grant[o];
      valid_d[o] = |arb_grant[o];
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (arb_grant[o][i])
          sel_d[o*PSIZE +: PSIZE] = PSIZE'(i);
      end
    end
  end

  assign bus.grant    = reset ? grant_any : '0;
  assign bus.out_lock = lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid   <= '0;
      bus.out_sel     <= '0;
      bus.err_invalid <= 1'b0;
    end else begin
      bus.out_valid   <= valid_d;
      bus.out_sel     <= sel_d;
      bus.err_invalid <= invalid_d;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: round robin, wormhole lock,
// backpressure, invalid codes and asynchronous reset.
module tb_switch_allocator;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  switch_allocator_if bus ();

  switch_allocator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_port  = '0;
    bus.out_ready = '1;
  endtask

  task automatic set_req(input int i, input logic [PSIZE-1:0] code, input logic last);
    bus.req_valid[i]              = 1'b1;
    bus.req_port[i*PSIZE +: PSIZE] = code;
    bus.req_last[i]               = last;
  endtask

  function automatic logic [PSIZE-1:0] sel_of(input int o);
    return bus.out_sel[o*PSIZE +: PSIZE];
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clear_req();
    #1 reset = 1'b0;
    set_req(0, PORT_L, 1'b1);
    #1;
    check("rst_grant", 32'(bus.grant), 32'h00);
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'h00);
    check("rst_lock", 32'(bus.out_lock), 32'h00);
    check("rst_err", 32'(bus.err_invalid), 32'h0);
    check("rst_sel", 32'(bus.out_sel), 32'h0);
    #2 reset = 1'b1;
    clear_req();
    tick();

    // single flit to L
    set_req(0, PORT_L, 1'b1);
    #1 check("t1_grant", 32'(bus.grant), 32'h01);
    tick();
    check("t1_valid", 32'(bus.out_valid), 32'h10);
    check("t1_sel4", 32'(sel_of(4)), 32'h0);
    check("t1_lock", 32'(bus.out_lock), 32'h00);
    set_req(1, PORT_L, 1'b1);
    #1 check("t1_ptr_grant", 32'(bus.grant), 32'h02);
    tick();
    check("t1_ptr_sel4", 32'(sel_of(4)), 32'h1);
    clear_req();

    // round robin on E
    set_req(0, PORT_E, 1'b1);
    set_req(2, PORT_E, 1'b1);
    set_req(3, PORT_E, 1'b1);
    #1 check("rr_g0", 32'(bus.grant), 32'h01);
    tick();
    check("rr_sel_a", 32'(sel_of(2)), 32'h0);
    bus.req_valid[0] = 1'b0;
    #1 check("rr_g2", 32'(bus.grant), 32'h04);
    tick();
    check("rr_sel_b", 32'(sel_of(2)), 32'h2);
    bus.req_valid[2] = 1'b0;
    #1 check("rr_g3", 32'(bus.grant), 32'h08);
    tick();
    check("rr_sel_c", 32'(sel_of(2)), 32'h3);
    check("rr_valid_c", 32'(bus.out_valid), 32'h04);
    bus.req_valid[3] = 1'b0;
    set_req(0, PORT_E, 1'b1);
    set_req(2, PORT_E, 1'b1);
    #1 check("rr_wrap", 32'(bus.grant), 32'h01);
    tick();
    clear_req();

    // wormhole lock on S with backpressure, bubble and a redirected owner
    set_req(1, PORT_S, 1'b0);
    set_req(4, PORT_S, 1'b1);
    #1 check("wh_f1", 32'(bus.grant), 32'h02);
    tick();
    check("wh_lock1", 32'(bus.out_lock), 32'h02);
    check("wh_sel1", 32'(sel_of(1)), 32'h1);
    #1 check("wh_f2", 32'(bus.grant), 32'h02);
    tick();
    check("wh_lock2", 32'(bus.out_lock), 32'h02);
    bus.out_ready[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1 check("bp_grant", 32'(bus.grant), 32'h00);
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'h00);
      check("bp_lock", 32'(bus.out_lock), 32'h02);
    end
    bus.out_ready[1] = 1'b1;
    bus.req_valid[1] = 1'b0;
    #1 check("bub_grant", 32'(bus.grant), 32'h00);
    tick();
    check("bub_valid", 32'(bus.out_valid), 32'h00);
    check("bub_lock", 32'(bus.out_lock), 32'h02);
    set_req(1, PORT_N, 1'b0);
    #1 check("redir_grant", 32'(bus.grant), 32'h00);
    tick();
    check("redir_lock", 32'(bus.out_lock), 32'h02);
    set_req(1, PORT_S, 1'b1);
    #1 check("wh_f3", 32'(bus.grant), 32'h02);
    tick();
    check("wh_unlock", 32'(bus.out_lock), 32'h00);
    check("wh_valid3", 32'(bus.out_valid), 32'h02);
    bus.req_valid[1] = 1'b0;
    #1 check("wh_next", 32'(bus.grant), 32'h10);
    tick();
    check("wh_next_sel", 32'(sel_of(1)), 32'h4);
    clear_req();

    // parallel grants plus an invalid code
    set_req(0, PORT_N, 1'b1);
    set_req(1, PORT_W, 1'b1);
    set_req(2, 3'd7, 1'b1);
    #1 check("par_grant", 32'(bus.grant), 32'h03);
    tick();
    check("par_err", 32'(bus.err_invalid), 32'h1);
    check("par_valid", 32'(bus.out_valid), 32'h09);
    check("par_sel3", 32'(sel_of(3)), 32'h1);
    bus.req_valid[1:0] = 2'b00;
    #1 check("inv_grant", 32'(bus.grant), 32'h00);
    tick();
    check("inv_err_hold", 32'(bus.err_invalid), 32'h1);
    clear_req();
    tick();
    check("inv_err_clr", 32'(bus.err_invalid), 32'h0);

    // reset mid-packet: E pointer is 1 before reset, 0 after
    set_req(3, PORT_E, 1'b0);
    set_req(0, PORT_E, 1'b1);
    #1 check("mr_grant", 32'(bus.grant), 32'h08);
    tick();
    check("mr_lock", 32'(bus.out_lock), 32'h04);
    check("mr_valid", 32'(bus.out_valid), 32'h04);
    #2 reset = 1'b0;
    #1;
    check("mr_lock_rst", 32'(bus.out_lock), 32'h00);
    check("mr_valid_rst", 32'(bus.out_valid), 32'h00);
    check("mr_grant_rst", 32'(bus.grant), 32'h00);
    tick();
    reset = 1'b1;
    #1 check("mr_after", 32'(bus.grant), 32'h01);
    tick();
    check("mr_after_sel", 32'(sel_of(2)), 32'h0);
    clear_req();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output-port allocator for the 5-port router (N, S, E, W, L).
- Takes each input module's route decision (3-bit port code) and a flit-available flag, and arbitrates round-robin among inputs contending for the same output.
- Holds an output for the whole packet (wormhole lock until the tail flit) and drives the input-FIFO read strobes and the crossbar select/valid.
- Sits between the input_module instances and the crossbar/output registers.

Parameters:
- NPORTS, 5, number of router ports (inputs = outputs); port index equals port code.
- PSIZE, 3, width of a port code and of a crossbar select field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NPORTS  input i holds a flit at its FIFO head.
- req_port  input  NPORTS*PSIZE  field i = requested output code for input i (N=0, S=1, E=2, W=3, L=4; 5–7 invalid).
- req_last  input  NPORTS  head flit of input i is the packet tail (single-flit packet: 1).
- out_ready  input  NPORTS  output o can accept a flit this cycle.
- grant  output  NPORTS  combinational read strobe to input i; the flit is consumed this cycle.
- out_valid  output  NPORTS  registered; a flit is on crossbar output o this cycle.
- out_sel  output  NPORTS*PSIZE  registered; field o = input index driving output o.
- out_lock  output  NPORTS  registered; output o is mid-packet.
- err_invalid  output  1  registered one-cycle pulse when any valid request carries code 5–7.

Behaviour:
- State per output o: lock_q[o], owner_q[o] (PSIZE bits), rr_ptr_q[o] (PSIZE bits, range 0..4).
- Reset (reset=0, asynchronous):
  - all state cleared, rr_ptr=0.
  - grant=0 (gated), out_valid=0, out_sel=0, out_lock=0, err_invalid=0.
  - A packet in progress is abandoned; the lock is cleared.
- Candidate set for output o: inputs i with req_valid[i]=1 and req_port field i == o.
- Output o, unlocked, out_ready[o]=1, candidates non-empty:
  - winner = first candidate at or after rr_ptr_q[o], searching cyclically 0..4 with wrap 4→0.
  - grant[winner]=1 in the same cycle.
- Output o, locked: only owner_q[o] is eligible. It is granted when req_valid[owner]=1, its code == o, and out_ready[o]=1.
- out_ready[o]=0: no grant to o; lock and pointer unchanged.
- On a granted flit with req_last=0: lock_q[o]←1, owner_q[o]←winner. rr_ptr is unchanged.
- On a granted flit with req_last=1: lock_q[o]←0, rr_ptr_q[o]←(winner+1) mod 5. A single-flit packet therefore never sets the lock.
- Latency:
  - grant is same-cycle (0).
  - out_valid[o] and out_sel[o] are asserted the cycle after the grant, aligned with the 1-cycle FIFO read latency.
- Locked owner with req_valid=0 (bubble): lock is held, no grant, out_valid[o]=0 next cycle.
- Locked owner requesting a different code: not granted anywhere (it is not a candidate for other outputs while it owns a lock); lock is held.
- Invalid code (5–7): never granted; err_invalid pulses next cycle; the request stays pending.
- At most one grant per input, since each input requests a single code. Different outputs grant in parallel in the same cycle.
- A grant never issues while reset=0.

Decomposition:
- Shared package noc_pkg:
  - port codes N/S/E/W/L/INVALID (3'b000…3'b100, 3'b111).
  - NPORTS and PSIZE.
  - these must replace the local port-code defines in other blocks.
- One sub-module, output_arbiter (one output: candidate mask in, lock/owner/rr_ptr state, one-hot grant out), instantiated NPORTS times.
- The top level does request decoding, OR-reduces grants per input, and holds the out_valid/out_sel registers.

Test Plan:
- Reset then single flit: req_valid=5'b00001, input 0 code=L(4), req_last=1, out_ready=all 1
  → grant=5'b00001 in the same cycle; next cycle out_valid[4]=1, out_sel[4]=0, out_lock=0; rr_ptr[4]=1.
- Round robin: inputs 0, 2, 3 all request E(2) with single-flit packets, valid held for 3 cycles
  → grants 0, 2, 3 on consecutive cycles; a 4th cycle with input 0 re-requesting → grant 0 (wrap).
- Wormhole lock: input 1 sends a 3-flit packet to S (last only on the 3rd flit) while input 4 also requests S
  → input 1 granted 3 consecutive cycles with out_lock[1]=1, then input 4 granted on cycle 4.
- Backpressure and bubble: mid-packet, out_ready[S]=0 for 2 cycles, then the owner's req_valid=0 for 1 cycle
  → no grants for 3 cycles, out_lock[S] stays 1, no other input is granted S.
- Parallel and invalid: input 0→N, input 1→W, input 2 code 7, all in the same cycle
  → grant=5'b00011, and err_invalid=1 on the next cycle.
- Reset mid-packet: assert reset=0 asynchronously while locked
  → out_lock=0, out_valid=0 immediately; after release, the pending request arbitrates from rr_ptr=0.
